// File: rtl/ccip_rdreq_tracker.sv
// ccip_rdreq_tracker: passive CCI-P C0 read request/response tracker.
// Optional latency statistics ports: define CCIP_RDTRACK_LATSTATS_EN.
module ccip_rdreq_tracker #(
    parameter int DEPTH       = 32,
    parameter int MDATA_W     = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int AGE_W       = 16
) (
    input  logic                         clk,
    input  logic                         SoftReset_n,
    input  logic                         tx_rd_valid,
    input  logic [MDATA_W-1:0]           tx_mdata,
    input  logic [1:0]                   tx_len,
    input  logic                         rx_rd_valid,
    input  logic [MDATA_W-1:0]           rx_mdata,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic [$clog2(DEPTH+1)-1:0]   watermark,
    output logic                         evt_valid,
    output logic [1:0]                   evt_code,
    output logic [MDATA_W-1:0]           evt_mdata,
    output logic [2:0]                   err_sticky
`ifdef CCIP_RDTRACK_LATSTATS_EN
    ,
    output logic [AGE_W-1:0]             lat_min,
    output logic [AGE_W-1:0]             lat_max,
    output logic [47:0]                  lat_sum,
    output logic [31:0]                  lat_cnt
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] TMO_AGE = AGE_W'(TIMEOUT_CYC);

    localparam logic [1:0] EVT_ORPHAN  = 2'b01;
    localparam logic [1:0] EVT_OVERFLOW = 2'b10;
    localparam logic [1:0] EVT_TIMEOUT = 2'b11;

    // Entry table
    logic [DEPTH-1:0]   r_vld;
    logic [DEPTH-1:0]   r_tmo;
    logic [MDATA_W-1:0] r_mdata [DEPTH];
    logic [1:0]         r_len   [DEPTH];
    logic [1:0]         r_rcvd  [DEPTH];
    logic [AGE_W-1:0]   r_age   [DEPTH];

    // Counters and event registers
    logic [CNT_W-1:0]   r_out;
    logic [CNT_W-1:0]   r_wm;
    logic               r_evt_valid;
    logic [1:0]         r_evt_code;
    logic [MDATA_W-1:0] r_evt_mdata;
    logic [2:0]         r_sticky;

    // Search results
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_free_ok;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic               w_tmo;
    logic [IDX_W-1:0]   w_tmo_idx;

    logic               w_rx_hit;
    logic               w_free;
    logic               w_alloc;
    logic               w_orphan;
    logic               w_ovf;
    logic               w_tmo_rpt;
    logic [CNT_W-1:0]   w_out_nxt;

    // Priority searches over the start-of-cycle table; lowest index wins
    always_comb begin
        w_hit       = 1'b0;
        w_hit_idx   = '0;
        w_free_ok   = 1'b0;
        w_alloc_idx = '0;
        w_tmo       = 1'b0;
        w_tmo_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_mdata[i] == rx_mdata)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_vld[i]) begin
                w_free_ok   = 1'b1;
                w_alloc_idx = IDX_W'(i);
            end
            if (r_vld[i] && !r_tmo[i] && (r_age[i] >= TMO_AGE)) begin
                w_tmo     = 1'b1;
                w_tmo_idx = IDX_W'(i);
            end
        end
    end

    // Per-cycle decisions derived from the searches
    always_comb begin
        w_rx_hit  = rx_rd_valid && w_hit;
        w_free    = w_rx_hit && (r_rcvd[w_hit_idx] == r_len[w_hit_idx]);
        w_alloc   = tx_rd_valid && w_free_ok;
        w_orphan  = rx_rd_valid && !w_hit;
        w_ovf     = tx_rd_valid && !w_free_ok;
        w_tmo_rpt = w_tmo && !w_orphan && !w_ovf;
        w_out_nxt = r_out;
        if (w_alloc && !w_free) begin
            w_out_nxt = r_out + CNT_W'(1);
        end else if (!w_alloc && w_free) begin
            w_out_nxt = r_out - CNT_W'(1);
        end
    end

    // Entry table update: aging, response counting, free, timeout flag, allocate
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_vld <= '0;
            r_tmo <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mdata[i] <= '0;
                r_len[i]   <= '0;
                r_rcvd[i]  <= '0;
                r_age[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && (r_age[i] != AGE_MAX)) begin
                    r_age[i] <= r_age[i] + AGE_W'(1);
                end
                if (w_rx_hit && (w_hit_idx == IDX_W'(i))) begin
                    if (w_free) begin
                        r_vld[i] <= 1'b0;
                    end else begin
                        r_rcvd[i] <= r_rcvd[i] + 2'd1;
                    end
                end
                if (w_tmo_rpt && (w_tmo_idx == IDX_W'(i))) begin
                    r_tmo[i] <= 1'b1;
                end
                if (w_alloc && (w_alloc_idx == IDX_W'(i))) begin
                    r_vld[i]   <= 1'b1;
                    r_tmo[i]   <= 1'b0;
                    r_mdata[i] <= tx_mdata;
                    r_len[i]   <= tx_len;
                    r_rcvd[i]  <= 2'd0;
                    r_age[i]   <= '0;
                end
            end
        end
    end

    // Outstanding count and high watermark (watermark lags by one cycle)
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_out <= '0;
            r_wm  <= '0;
        end else begin
            r_out <= w_out_nxt;
            r_wm  <= (r_out > r_wm) ? r_out : r_wm;
        end
    end

    // Registered event record with orphan > overflow > timeout priority
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_evt_valid <= 1'b0;
            r_evt_code  <= 2'b00;
            r_evt_mdata <= '0;
            r_sticky    <= 3'b000;
        end else begin
            r_evt_valid <= w_orphan || w_ovf || w_tmo;
            r_sticky    <= r_sticky | {w_tmo, w_ovf, w_orphan};
            if (w_orphan) begin
                r_evt_code  <= EVT_ORPHAN;
                r_evt_mdata <= rx_mdata;
            end else if (w_ovf) begin
                r_evt_code  <= EVT_OVERFLOW;
                r_evt_mdata <= tx_mdata;
            end else if (w_tmo) begin
                r_evt_code  <= EVT_TIMEOUT;
                r_evt_mdata <= r_mdata[w_tmo_idx];
            end else begin
                r_evt_code  <= 2'b00;
                r_evt_mdata <= '0;
            end
        end
    end

    assign outstanding = r_out;
    assign watermark   = r_wm;
    assign evt_valid   = r_evt_valid;
    assign evt_code    = r_evt_code;
    assign evt_mdata   = r_evt_mdata;
    assign err_sticky  = r_sticky;

`ifdef CCIP_RDTRACK_LATSTATS_EN
    localparam logic [47:0] SUM_MAX = '1;
    localparam logic [31:0] CNT_MAX = '1;

    logic [AGE_W-1:0] r_lat_min;
    logic [AGE_W-1:0] r_lat_max;
    logic [47:0]      r_lat_sum;
    logic [31:0]      r_lat_cnt;
    logic [AGE_W-1:0] w_lat;
    logic [47:0]      w_lat_ext;

    // Latency of the freed entry is its age plus the final response cycle
    always_comb begin
        w_lat = r_age[w_hit_idx];
        if (w_lat != AGE_MAX) begin
            w_lat = w_lat + AGE_W'(1);
        end
        w_lat_ext = 48'(w_lat);
    end

    // Saturating latency statistics, updated on every entry free
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_lat_min <= '1;
            r_lat_max <= '0;
            r_lat_sum <= '0;
            r_lat_cnt <= '0;
        end else if (w_free) begin
            if (w_lat < r_lat_min) begin
                r_lat_min <= w_lat;
            end
            if (w_lat > r_lat_max) begin
                r_lat_max <= w_lat;
            end
            if (r_lat_sum > (SUM_MAX - w_lat_ext)) begin
                r_lat_sum <= SUM_MAX;
            end else begin
                r_lat_sum <= r_lat_sum + w_lat_ext;
            end
            if (r_lat_cnt != CNT_MAX) begin
                r_lat_cnt <= r_lat_cnt + 32'd1;
            end
        end
    end

    assign lat_min = r_lat_min;
    assign lat_max = r_lat_max;
    assign lat_sum = r_lat_sum;
    assign lat_cnt = r_lat_cnt;
`endif

endmodule

// File: tb/tb_ccip_rdreq_tracker.sv
// tb_ccip_rdreq_tracker: directed and randomized checks of the C0 read tracker
// against an entry-table reference model.
module tb_ccip_rdreq_tracker;

    localparam int DEPTH = 32;
    localparam int MW    = 16;
    localparam int TMO   = 16;
    localparam int AW    = 16;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AMAX  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          SoftReset_n = 1'b1;
    logic          tx_rd_valid = 1'b0;
    logic [MW-1:0] tx_mdata = '0;
    logic [1:0]    tx_len = '0;
    logic          rx_rd_valid = 1'b0;
    logic [MW-1:0] rx_mdata = '0;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] watermark;
    logic          evt_valid;
    logic [1:0]    evt_code;
    logic [MW-1:0] evt_mdata;
    logic [2:0]    err_sticky;
`ifdef CCIP_RDTRACK_LATSTATS_EN
    logic [AW-1:0] lat_min;
    logic [AW-1:0] lat_max;
    logic [47:0]   lat_sum;
    logic [31:0]   lat_cnt;
`endif

    ccip_rdreq_tracker #(
        .DEPTH(DEPTH), .MDATA_W(MW), .TIMEOUT_CYC(TMO), .AGE_W(AW)
    ) dut (
        .clk(clk),
        .SoftReset_n(SoftReset_n),
        .tx_rd_valid(tx_rd_valid),
        .tx_mdata(tx_mdata),
        .tx_len(tx_len),
        .rx_rd_valid(rx_rd_valid),
        .rx_mdata(rx_mdata),
        .outstanding(outstanding),
        .watermark(watermark),
        .evt_valid(evt_valid),
        .evt_code(evt_code),
        .evt_mdata(evt_mdata),
        .err_sticky(err_sticky)
`ifdef CCIP_RDTRACK_LATSTATS_EN
        ,
        .lat_min(lat_min),
        .lat_max(lat_max),
        .lat_sum(lat_sum),
        .lat_cnt(lat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_tmo_ev = 0;

    // Reference model: table of outstanding requests
    bit       m_vld [DEPTH];
    int       m_md  [DEPTH];
    int       m_len [DEPTH];
    int       m_rc  [DEPTH];
    int       m_age [DEPTH];
    bit       m_tf  [DEPTH];
    int       m_out;
    int       m_wm;
    bit [2:0] m_stk;
    bit       m_ev;
    int       m_code;
    int       m_evmd;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 0; m_md[i] = 0; m_len[i] = 0;
            m_rc[i] = 0; m_age[i] = 0; m_tf[i] = 0;
        end
        m_out = 0; m_wm = 0; m_stk = 0;
        m_ev = 0; m_code = 0; m_evmd = 0;
    endfunction

    function automatic void m_step(bit tv, int tmd, int tl, bit rv, int rmd);
        int hit = -1;
        int al = -1;
        int cand = -1;
        bit orph;
        bit ovf;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit < 0 && rv && m_vld[i] && m_md[i] == rmd) hit = i;
            if (al < 0 && tv && !m_vld[i]) al = i;
            if (cand < 0 && m_vld[i] && !m_tf[i] && m_age[i] >= TMO) cand = i;
        end
        orph = rv && hit < 0;
        ovf = tv && al < 0;
        m_ev = orph || ovf || cand >= 0;
        m_code = 0;
        m_evmd = 0;
        if (orph) begin
            m_code = 1; m_evmd = rmd;
        end else if (ovf) begin
            m_code = 2; m_evmd = tmd;
        end else if (cand >= 0) begin
            m_code = 3; m_evmd = m_md[cand]; m_tf[cand] = 1;
        end
        m_stk = m_stk | {cand >= 0, ovf, orph};
        if (m_out > m_wm) m_wm = m_out;
        for (int i = 0; i < DEPTH; i++)
            if (m_vld[i] && m_age[i] < AMAX) m_age[i]++;
        if (hit >= 0) begin
            if (m_rc[hit] == m_len[hit]) m_vld[hit] = 0;
            else m_rc[hit]++;
        end
        if (al >= 0) begin
            m_vld[al] = 1; m_md[al] = tmd; m_len[al] = tl;
            m_rc[al] = 0; m_age[al] = 0; m_tf[al] = 0;
        end
        m_out = 0;
        for (int i = 0; i < DEPTH; i++) if (m_vld[i]) m_out++;
    endfunction

    task automatic cyc(input bit tv, input int tmd, input int tl,
                       input bit rv, input int rmd);
        tx_rd_valid = tv;
        tx_mdata = MW'(tmd);
        tx_len = 2'(tl);
        rx_rd_valid = rv;
        rx_mdata = MW'(rmd);
        @(posedge clk);
        if (SoftReset_n) m_step(tv, tmd, tl, rv, rmd);
        else m_reset();
        #1;
        chk("outstanding", outstanding, m_out);
        chk("watermark", watermark, m_wm);
        chk("evt_valid", evt_valid, m_ev);
        if (m_ev) begin
            chk("evt_code", evt_code, m_code);
            chk("evt_mdata", evt_mdata, m_evmd);
        end
        chk("err_sticky", err_sticky, m_stk);
        if (evt_valid && evt_code == 2'b11) n_tmo_ev++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        SoftReset_n = 1'b0;
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_watermark", watermark, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_code", evt_code, 0);
        chk("rst_evt_mdata", evt_mdata, 0);
        chk("rst_err_sticky", err_sticky, 0);
        m_reset();
        idle(2);
        SoftReset_n = 1'b1;
    endtask

    initial begin
        m_reset();
        #3;
        do_reset();

        // Single 1CL request answered 4 cycles later
        cyc(1, 'h12, 0, 0, 0);
        chk("t1_out_up", outstanding, 1);
        idle(3);
        cyc(0, 0, 0, 1, 'h12);
        chk("t1_out_down", outstanding, 0);
        idle(2);
        chk("t1_wm", watermark, 1);

        // 4CL request: freed after 4th response, 5th is orphan
        cyc(1, 'hA0, 3, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 'hA0);
        chk("t2_still_out", outstanding, 1);
        cyc(0, 0, 0, 1, 'hA0);
        chk("t2_freed", outstanding, 0);
        cyc(0, 0, 0, 1, 'hA0);
        chk("t2_orph_code", evt_code, 1);
        chk("t2_orph_md", evt_mdata, 'hA0);
        chk("t2_sticky", err_sticky, 3'b001);
        idle(2);

        // Fill all entries, overflow on the 33rd, same-cycle free/overflow
        do_reset();
        for (int k = 0; k < DEPTH; k++)
            cyc(1, (k == 0) ? 'h5 : ('h100 + k), 0, 0, 0);
        cyc(1, 'h7, 0, 0, 0);
        chk("t3_ovf_code", evt_code, 2);
        chk("t3_ovf_md", evt_mdata, 'h7);
        chk("t3_out_full", outstanding, 32);
        chk("t3_wm_full", watermark, 32);
        cyc(1, 'h7, 0, 1, 'h5);
        chk("t5_ovf_code", evt_code, 2);
        chk("t5_no_orph", err_sticky[0], 0);
        chk("t5_freed", outstanding, 31);
        cyc(1, 'h7, 0, 0, 0);
        chk("t5_realloc", outstanding, 32);
        idle(4);

        // Timeouts: three consecutive requests, no responses
        do_reset();
        n_tmo_ev = 0;
        cyc(1, 'h21, 0, 0, 0);
        cyc(1, 'h22, 0, 0, 0);
        cyc(1, 'h23, 0, 0, 0);
        idle(24);
        chk("t4_tmo_count", n_tmo_ev, 3);
        chk("t4_sticky_tmo", err_sticky[2], 1);
        chk("t4_still_out", outstanding, 3);

        // Reset mid-traffic with 10 outstanding, later response is orphan
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1, 'h40 + k, 1, 0, 0);
        chk("t6_out10", outstanding, 10);
        do_reset();
        cyc(0, 0, 0, 1, 'h40);
        chk("t6_orph_code", evt_code, 1);
        chk("t6_orph_md", evt_mdata, 'h40);
        idle(2);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit tv;
            bit rv;
            int tmd;
            int rmd;
            int pick;
            if ($urandom_range(0, 799) == 0) do_reset();
            tv = ($urandom_range(0, 99) < 45);
            rv = ($urandom_range(0, 99) < 60);
            tmd = $urandom_range(0, 15);
            pick = $urandom_range(0, DEPTH - 1);
            if (m_vld[pick] && $urandom_range(0, 3) != 0) rmd = m_md[pick];
            else rmd = $urandom_range(0, 15);
            cyc(tv, tmd, $urandom_range(0, 3), rv, rmd);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
